branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch/jump resolution in EX: computes direction and target, updates the predictor,
// redirects the front end on a mispredict and drops the wrong-path slots that follow.
`ifndef RST_EN
`define RST_EN 1'b0
`endif

module branch_resolve #(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             ck_i,
    input  logic             rs_n_i,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [31:0]      pc_i,
    input  logic [2:0]       br_op_i,
    input  logic             is_br_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic [31:0]      imm_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_pc_i,
    output logic             branch_request_o,
    output logic             branch_is_taken_o,
    output logic             branch_is_call_o,
    output logic             branch_is_ret_o,
    output logic             branch_is_jmp_o,
    output logic             branch_mispredict_o,
    output logic [31:0]      branch_source_o,
    output logic [31:0]      branch_target_o,
    output logic             flush_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  sq_cnt_q, sq_cnt_d;
    logic        class_ok, accept, drop;

    logic signed [31:0] rs1_s, rs2_s;
    logic        jump_p0, taken_p0, call_p0, ret_p0, jmp_p0, mis_p0;
    logic [31:0] jalr_sum_p0, target_p0, redirect_p0;

    logic             vld_p1, taken_p1, call_p1, ret_p1, jmp_p1, mis_p1;
    logic [31:0]      source_p1, target_p1, redirect_p1;
    logic [CNT_W-1:0] br_cnt_p1, mis_cnt_p1;

    // ---- stage p0: combinational resolution of the instruction in EX ----
    assign rs1_s       = rs1_data_i;
    assign rs2_s       = rs2_data_i;
    assign jump_p0     = is_jal_i | is_jalr_i;
    assign jalr_sum_p0 = rs1_data_i + imm_i;
    assign class_ok    = $onehot({is_br_i, is_jal_i, is_jalr_i});

    always_comb begin
        taken_p0 = 1'b0;
        if (jump_p0) begin
            taken_p0 = 1'b1;
        end else if (is_br_i) begin
            case (br_op_i)
                3'b000:  taken_p0 = (rs1_data_i == rs2_data_i);
                3'b001:  taken_p0 = (rs1_data_i != rs2_data_i);
                3'b100:  taken_p0 = (rs1_s < rs2_s);
                3'b101:  taken_p0 = (rs1_s >= rs2_s);
                3'b110:  taken_p0 = (rs1_data_i < rs2_data_i);
                3'b111:  taken_p0 = (rs1_data_i >= rs2_data_i);
                default: taken_p0 = 1'b0;
            endcase
        end
    end

    // A link-register rd wins over the return pattern, so call and ret never both fire.
    assign target_p0   = is_jalr_i ? {jalr_sum_p0[31:1], 1'b0} : pc_i + imm_i;
    assign call_p0     = jump_p0 & is_link(rd_i);
    assign ret_p0      = is_jalr_i & (rd_i == 5'd0) & is_link(rs1_i) & ~call_p0;
    assign jmp_p0      = jump_p0 & ~call_p0 & ~ret_p0;
    assign mis_p0      = (taken_p0 != pred_taken_i) | (taken_p0 & (target_p0 != pred_pc_i));
    assign redirect_p0 = taken_p0 ? target_p0 : pc_i + 32'd4;

    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (rs_n_i == `RST_EN) begin
            state_q  <= RUN;
            sq_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            RUN: begin
                if (accept && mis_p0) begin
                    state_d  = SQUASH;
                    sq_cnt_d = SQ_LOAD;
                end
            end
            SQUASH: begin
                if (drop) begin
                    sq_cnt_d = sq_cnt_q - 4'd1;
                    if (sq_cnt_q <= 4'd1) begin
                        state_d  = RUN;
                        sq_cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d  = RUN;
                sq_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        if (valid_i && !stall_i) begin
            if (state_q == RUN) accept = class_ok;
            else                drop   = 1'b1;
        end
    end

    // ---- stage p1: registered predictor update, redirect and counters ----
    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (rs_n_i == `RST_EN) begin
            vld_p1      <= 1'b0;
            taken_p1    <= 1'b0;
            call_p1     <= 1'b0;
            ret_p1      <= 1'b0;
            jmp_p1      <= 1'b0;
            mis_p1      <= 1'b0;
            source_p1   <= 32'd0;
            target_p1   <= 32'd0;
            redirect_p1 <= 32'd0;
            br_cnt_p1   <= '0;
            mis_cnt_p1  <= '0;
        end else begin
            vld_p1 <= accept;
            mis_p1 <= accept & mis_p0;
            if (accept) begin
                taken_p1    <= taken_p0;
                call_p1     <= call_p0;
                ret_p1      <= ret_p0;
                jmp_p1      <= jmp_p0;
                source_p1   <= pc_i;
                target_p1   <= target_p0;
                redirect_p1 <= redirect_p0;
                br_cnt_p1   <= sat_inc(br_cnt_p1);
                if (mis_p0) mis_cnt_p1 <= sat_inc(mis_cnt_p1);
            end
        end
    end

    assign branch_request_o    = vld_p1;
    assign branch_is_taken_o   = taken_p1;
    assign branch_is_call_o    = call_p1;
    assign branch_is_ret_o     = ret_p1;
    assign branch_is_jmp_o     = jmp_p1;
    assign branch_mispredict_o = mis_p1;
    assign flush_o             = mis_p1;
    assign branch_source_o     = source_p1;
    assign branch_target_o     = target_p1;
    assign redirect_pc_o       = redirect_p1;
    assign br_cnt_o            = br_cnt_p1;
    assign mis_cnt_o           = mis_cnt_p1;

endmodule
